// File: rtl/load_store_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | load_store_unit_if : pipeline request/response and data-memory port bundle |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface load_store_unit_if;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [1:0]  reqSize;
  logic        reqUnsigned;
  logic [31:0] reqAddr;
  logic [31:0] reqWData;
  logic        respValid;
  logic        respErr;
  logic [31:0] respRData;
  logic [31:0] mem_address;
  logic        mem_writeEnable;
  logic [31:0] mem_writeData;
  logic [31:0] mem_readData;

  // slave: the load/store unit itself; master: pipeline plus memory around it
  modport slave (
    input  reqValid, reqWrite, reqSize, reqUnsigned, reqAddr, reqWData, mem_readData,
    output reqReady, respValid, respErr, respRData, mem_address, mem_writeEnable,
           mem_writeData
  );

  modport master (
    output reqValid, reqWrite, reqSize, reqUnsigned, reqAddr, reqWData, mem_readData,
    input  reqReady, respValid, respErr, respRData, mem_address, mem_writeEnable,
           mem_writeData
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | load_store_unit : MEM-stage sequencer for a little-endian 32-bit data      |
// | memory with read-modify-write sub-word stores and extending loads.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module load_store_unit #(
  parameter int READ_LATENCY = 1
) (
  input  wire              clk,
  input  wire              reset,
  load_store_unit_if.slave bus
);

  localparam int              CNT_W     = $clog2(READ_LATENCY + 1) + 1;
  localparam logic [CNT_W-1:0] c_RD_LAST = CNT_W'(READ_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_RESP = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_write;
  logic [1:0]       r_size;
  logic             r_unsigned;
  logic [1:0]       r_lane;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  logic [31:0]      r_addr;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_misaligned;
  logic             w_rd_last;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_merged;
  logic [31:0]      w_loaded;

  assign bus.reqReady = (r_state == S_IDLE) && !reset;
  assign w_accept     = bus.reqValid && bus.reqReady;
  assign w_rd_last    = (r_state == S_RD) && (r_cnt == c_RD_LAST);

  always_comb begin
    w_misaligned = 1'b0;
    case (bus.reqSize)
      2'b01:   w_misaligned = bus.reqAddr[0];
      2'b10:   w_misaligned = (bus.reqAddr[1:0] != 2'b00);
      2'b11:   w_misaligned = 1'b1;
      default: w_misaligned = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_misaligned)
            w_next = S_ERR;
          else if (bus.reqWrite && (bus.reqSize == 2'b10))
            w_next = S_WR;
          else
            w_next = S_RD;
        end
      end
      S_RD:    if (w_rd_last) w_next = r_write ? S_WR : S_RESP;
      S_WR:    w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Only the addressed lane(s) of the sampled word are replaced by store data
  always_comb begin
    w_merged = bus.mem_readData;
    case (r_size)
      2'b00:   w_merged[{r_lane, 3'b000} +: 8]     = r_wdata[7:0];
      2'b01:   w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
      default: w_merged = bus.mem_readData;
    endcase
  end

  always_comb begin
    w_byte = bus.mem_readData[{r_lane, 3'b000} +: 8];
    w_half = bus.mem_readData[{r_lane[1], 4'b0000} +: 16];
    case (r_size)
      2'b00:   w_loaded = r_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_loaded = r_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_loaded = bus.mem_readData;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_write    <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_lane     <= 2'b00;
      r_wdata    <= 32'h0;
      r_rdata    <= 32'h0;
      r_addr     <= 32'h0;
      r_cnt      <= '0;
    end else begin
      if (w_accept) begin
        r_write    <= bus.reqWrite;
        r_size     <= bus.reqSize;
        r_unsigned <= bus.reqUnsigned;
        r_lane     <= bus.reqAddr[1:0];
        r_wdata    <= bus.reqWData;
        r_rdata    <= 32'h0;
        r_cnt      <= '0;
        // Faulting requests leave the memory port untouched
        if (!w_misaligned)
          r_addr <= {bus.reqAddr[31:2], 2'b00};
      end
      if (r_state == S_RD) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_rd_last) begin
          if (r_write)
            r_wdata <= w_merged;
          else
            r_rdata <= w_loaded;
        end
      end
    end
  end

  assign bus.mem_address     = r_addr;
  assign bus.mem_writeEnable = (r_state == S_WR) && !reset;
  assign bus.mem_writeData   = bus.mem_writeEnable ? r_wdata : 32'h0;
  assign bus.respValid       = ((r_state == S_RESP) || (r_state == S_ERR)) && !reset;
  assign bus.respErr         = (r_state == S_ERR) && !reset;
  assign bus.respRData       = ((r_state == S_RESP) && !r_write && !reset) ? r_rdata : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_load_store_unit : directed and random load/store traffic against a      |
// | byte-array reference memory, READ_LATENCY 1 and 3 instances.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_load_store_unit;

  logic clk = 1'b0;
  logic reset;
  logic init_mem;
  logic sel;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;

  load_store_unit_if if1 ();
  load_store_unit_if if3 ();

  load_store_unit #(.READ_LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
  load_store_unit #(.READ_LATENCY(3)) dut3 (.clk(clk), .reset(reset), .bus(if3.slave));

  logic [31:0] seed [256];
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] p3   [3];
  int          wr_cnt  [2];
  int          wr_cyc  [2];
  logic [31:0] wr_addr [2];
  logic [31:0] wr_data [2];
  logic [7:0]  rb [2][1024];

  // Memory models: registered read, one-stage for dut1, three-stage for dut3
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (init_mem) begin
      for (int i = 0; i < 256; i++) begin
        mem1[i] <= seed[i];
        mem3[i] <= seed[i];
      end
      wr_cnt[0] <= 0;
      wr_cnt[1] <= 0;
    end else begin
      if (if1.mem_writeEnable) begin
        mem1[if1.mem_address[9:2]] <= if1.mem_writeData;
        wr_cnt[0]  <= wr_cnt[0] + 1;
        wr_cyc[0]  <= cyc;
        wr_addr[0] <= if1.mem_address;
        wr_data[0] <= if1.mem_writeData;
      end
      if (if3.mem_writeEnable) begin
        mem3[if3.mem_address[9:2]] <= if3.mem_writeData;
        wr_cnt[1]  <= wr_cnt[1] + 1;
        wr_cyc[1]  <= cyc;
        wr_addr[1] <= if3.mem_address;
        wr_data[1] <= if3.mem_writeData;
      end
    end
    if1.mem_readData <= mem1[if1.mem_address[9:2]];
    p3[0] <= mem3[if3.mem_address[9:2]];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign if3.mem_readData = p3[2];

  logic        o_ready, o_rv, o_re;
  logic [31:0] o_rd;
  always_comb begin
    o_ready = sel ? if3.reqReady  : if1.reqReady;
    o_rv    = sel ? if3.respValid : if1.respValid;
    o_re    = sel ? if3.respErr   : if1.respErr;
    o_rd    = sel ? if3.respRData : if1.respRData;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int inst, input logic v, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] d);
    sel             = (inst == 1);
    if1.reqValid    = v && (inst == 0);
    if3.reqValid    = v && (inst == 1);
    if1.reqWrite    = wr;  if3.reqWrite    = wr;
    if1.reqSize     = sz;  if3.reqSize     = sz;
    if1.reqUnsigned = uns; if3.reqUnsigned = uns;
    if1.reqAddr     = a;   if3.reqAddr     = a;
    if1.reqWData    = d;   if3.reqWData    = d;
  endtask

  // One complete request, checked against the byte-array model
  task automatic run_op(input int inst, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] got_rd, output int lat);
    int          rl, n, acc, wc0, base, exp_lat;
    logic        err;
    longint      v;
    logic [31:0] exp_rd, exp_word;
    rl = (inst == 1) ? 3 : 1;
    drive(inst, 1'b1, wr, sz, uns, a, d);
    #1;
    chk("reqReady_before_accept", {31'h0, o_ready}, 32'h1);
    acc = cyc;
    wc0 = wr_cnt[inst];
    @(posedge clk); #1;
    drive(inst, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);

    n        = 1 << sz;
    err      = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    exp_rd   = 32'h0;
    exp_word = 32'h0;
    if (!err && !wr) begin
      v = 0;
      for (int i = 0; i < n; i++) v = v + (longint'(rb[inst][(a + i) & 1023]) << (8 * i));
      if (!uns && n < 4 && v[8 * n - 1]) v = v - (longint'(1) << (8 * n));
      exp_rd = v[31:0];
    end
    if (!err && wr) begin
      for (int i = 0; i < n; i++) rb[inst][(a + i) & 1023] = 8'(d >> (8 * i));
      base     = int'(a) & ~3;
      exp_word = {rb[inst][base + 3], rb[inst][base + 2], rb[inst][base + 1], rb[inst][base]};
    end
    exp_lat = err ? 1 : (wr ? ((sz == 2'b10) ? 2 : rl + 3) : rl + 2);

    lat = -1;
    for (int k = 0; k < 20; k++) begin
      if (o_rv) begin
        lat = cyc - acc;
        break;
      end
      @(posedge clk); #1;
    end
    got_rd = o_rd;
    chk("resp_latency", lat, exp_lat);
    chk("respErr", {31'h0, o_re}, {31'h0, err});
    chk("respRData", o_rd, exp_rd);
    @(posedge clk); #1;
    chk("respValid_single_pulse", {31'h0, o_rv}, 32'h0);
    chk("write_count", wr_cnt[inst] - wc0, (!err && wr) ? 1 : 0);
    if (!err && wr) begin
      chk("write_addr", wr_addr[inst], a & ~32'h3);
      chk("write_data", wr_data[inst], exp_word);
      chk("write_latency", wr_cyc[inst] - acc, (sz == 2'b10) ? 1 : rl + 2);
    end
  endtask

  logic [31:0] got;
  int          lat, acc, wc0;

  initial begin
    reset    = 1'b1;
    init_mem = 1'b1;
    drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 256; i++) seed[i] = $urandom;
    seed[32'h100 >> 2] = 32'h8899AABB;
    for (int i = 0; i < 256; i++)
      for (int b = 0; b < 4; b++) begin
        rb[0][4 * i + b] = seed[i][8 * b +: 8];
        rb[1][4 * i + b] = seed[i][8 * b +: 8];
      end
    repeat (3) @(posedge clk);
    #1;
    init_mem = 1'b0;
    chk("reset_respValid", {31'h0, if1.respValid}, 32'h0);
    chk("reset_respErr", {31'h0, if1.respErr}, 32'h0);
    chk("reset_respRData", if1.respRData, 32'h0);
    chk("reset_mem_address", if1.mem_address, 32'h0);
    chk("reset_mem_writeData", if1.mem_writeData, 32'h0);
    chk("reset_mem_writeEnable", {31'h0, if1.mem_writeEnable}, 32'h0);
    chk("reset_reqReady", {31'h0, if1.reqReady}, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_reqReady", {31'h0, if1.reqReady}, 32'h1);

    run_op(0, 1'b0, 2'b00, 1'b0, 32'h101, 32'h0, got, lat);
    chk("lb_101", got, 32'hFFFFFFAA);
    chk("lb_latency", lat, 3);
    run_op(0, 1'b0, 2'b00, 1'b1, 32'h101, 32'h0, got, lat);
    chk("lbu_101", got, 32'h000000AA);
    run_op(0, 1'b1, 2'b00, 1'b0, 32'h102, 32'h12345677, got, lat);
    chk("sb_102_word", wr_data[0], 32'h8877AABB);
    chk("sb_latency", lat, 4);
    run_op(0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h0000BEEF, got, lat);
    chk("sh_102_word", wr_data[0], 32'hBEEFAABB);
    run_op(0, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, got, lat);
    chk("lh_102", got, 32'hFFFFBEEF);
    run_op(0, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, got, lat);
    chk("lhu_102", got, 32'h0000BEEF);
    run_op(0, 1'b1, 2'b10, 1'b0, 32'h200, 32'hDEADBEEF, got, lat);
    chk("sw_latency", lat, 2);
    run_op(0, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, got, lat);
    chk("lw_200", got, 32'hDEADBEEF);
    run_op(1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, got, lat);
    chk("l3_lw_latency", lat, 5);
    run_op(1, 1'b1, 2'b10, 1'b0, 32'h200, 32'hDEADBEEF, got, lat);
    chk("l3_sw_latency", lat, 2);
    run_op(1, 1'b1, 2'b00, 1'b0, 32'h201, 32'h55, got, lat);
    chk("l3_sb_latency", lat, 6);
    run_op(0, 1'b0, 2'b10, 1'b0, 32'h203, 32'h0, got, lat);
    run_op(0, 1'b1, 2'b01, 1'b0, 32'h101, 32'hFFFF, got, lat);
    run_op(0, 1'b1, 2'b11, 1'b0, 32'h100, 32'hFFFF, got, lat);
    run_op(0, 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, got, lat);

    // Reset lands in the write cycle of a byte store
    drive(0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h102, 32'h000000C3);
    #1;
    acc = cyc;
    wc0 = wr_cnt[0];
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("abort_writeEnable", {31'h0, if1.mem_writeEnable}, 32'h0);
    chk("abort_reqReady_in_reset", {31'h0, if1.reqReady}, 32'h0);
    chk("abort_cycle", cyc - acc, 3);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("abort_reqReady_after", {31'h0, if1.reqReady}, 32'h1);
    chk("abort_no_resp", {31'h0, if1.respValid}, 32'h0);
    @(posedge clk); #1;
    chk("abort_no_resp_later", {31'h0, if1.respValid}, 32'h0);
    chk("abort_no_write", wr_cnt[0] - wc0, 0);
    run_op(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, got, lat);
    chk("abort_mem_unchanged", got, 32'hBEEFAABB);

    for (int i = 0; i < 80; i++)
      run_op((i % 4 == 3) ? 1 : 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)), $urandom, got, lat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
